// File: rtl/led_shifter.sv
// Frame-buffer readout: walks the frame buffer from the top address down and
// shifts each channel MSB-first into the LED driver chain, then latches and requests the next frame.
module led_shifter #(
  parameter int c_ledboards  = 30,
  parameter int c_bpc        = 12,
  parameter int c_channels   = c_ledboards * 32,
  parameter int c_addr_w     = $clog2(c_channels),
  parameter int c_clk_div    = 2,
  parameter int c_lat_cycles = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  output logic [c_addr_w-1:0] o_addr,
  input  logic [c_bpc-1:0]    i_data,
  output logic                o_sclk,
  output logic                o_sdi,
  output logic                o_lat,
  output logic                o_blank,
  output logic                o_drq,
  output logic                o_busy
);

  localparam int PH_W  = $clog2(2 * c_clk_div + 1);
  localparam int BIT_W = $clog2(c_bpc + 1);
  localparam int LAT_W = $clog2(c_lat_cycles + 1);

  localparam logic [c_addr_w-1:0] ADDR_TOP = c_addr_w'(c_channels - 1);
  localparam logic [PH_W-1:0]     PH_HI    = PH_W'(c_clk_div);
  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(2 * c_clk_div - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(c_bpc - 1);
  localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(c_lat_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DRQ
  } state_t;

  state_t              state_reg;
  logic [c_bpc-1:0]    shift_reg;
  logic [PH_W-1:0]     phase_reg;
  logic [BIT_W-1:0]    bit_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [c_addr_w-1:0] addr_reg;
  logic                sclk_reg;
  logic                lat_reg;
  logic                blank_reg;
  logic                drq_reg;
  logic                busy_reg;
  logic [PH_W-1:0]     phase_inc;

  assign phase_inc = phase_reg + PH_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      phase_reg   <= '0;
      bit_reg     <= '0;
      lat_cnt_reg <= '0;
      addr_reg    <= '0;
      sclk_reg    <= 1'b0;
      lat_reg     <= 1'b0;
      blank_reg   <= 1'b1;
      drq_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_en) begin
            addr_reg  <= ADDR_TOP;
            busy_reg  <= 1'b1;
            state_reg <= S_FETCH;
          end
        end

        // Address was presented on entry; the RAM needs this cycle to respond.
        S_FETCH: begin
          state_reg <= S_LOAD;
        end

        S_LOAD: begin
          shift_reg <= i_data;
          phase_reg <= '0;
          bit_reg   <= '0;
          sclk_reg  <= 1'b0;
          state_reg <= S_SHIFT;
        end

        S_SHIFT: begin
          if (phase_reg == PH_LAST) begin
            // End of the high phase: drop sclk and move on to the next bit.
            phase_reg <= '0;
            sclk_reg  <= 1'b0;
            shift_reg <= {shift_reg[c_bpc-2:0], 1'b0};
            bit_reg   <= bit_reg + BIT_W'(1);
            if (bit_reg == BIT_LAST) begin
              if (addr_reg == '0) begin
                lat_reg     <= 1'b1;
                lat_cnt_reg <= '0;
                state_reg   <= S_LATCH;
              end else begin
                addr_reg  <= addr_reg - c_addr_w'(1);
                state_reg <= S_FETCH;
              end
            end
          end else begin
            phase_reg <= phase_inc;
            sclk_reg  <= (phase_inc >= PH_HI);
          end
        end

        S_LATCH: begin
          if (lat_cnt_reg == LAT_LAST) begin
            lat_reg   <= 1'b0;
            blank_reg <= 1'b0;
            drq_reg   <= 1'b1;
            state_reg <= S_DRQ;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end

        S_DRQ: begin
          drq_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // The shift register empties itself by the end of each channel, so its MSB
  // doubles as the idle-low serial data output.
  assign o_sdi   = shift_reg[c_bpc-1];
  assign o_addr  = addr_reg;
  assign o_sclk  = sclk_reg;
  assign o_lat   = lat_reg;
  assign o_blank = blank_reg;
  assign o_drq   = drq_reg;
  assign o_busy  = busy_reg;

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: a 32-channel instance (div 1, 12 bpc) driven through directed
// phases with random buffer contents, plus a div-3 / 8-bpc instance free-running.
module tb_led_shifter;
  localparam int C      = 32;
  localparam int B      = 12;
  localparam int D      = 1;
  localparam int L      = 2;
  localparam int FRAME  = 1 + C * (2 + 2 * D * B) + L + 1;
  localparam int B2     = 8;
  localparam int D2     = 3;
  localparam int FRAME2 = 1 + C * (2 + 2 * D2 * B2) + L + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, rst2, en2;
  logic [4:0]  addr, addr2;
  logic [11:0] data;
  logic [7:0]  data2;
  logic        sclk, sdi, lat, blank, drq, busy;
  logic        sclk2, sdi2, lat2, blank2, drq2, busy2;

  led_shifter #(.c_ledboards(1), .c_bpc(B), .c_clk_div(D), .c_lat_cycles(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_addr(addr), .i_data(data),
    .o_sclk(sclk), .o_sdi(sdi), .o_lat(lat), .o_blank(blank), .o_drq(drq), .o_busy(busy)
  );

  led_shifter #(.c_ledboards(1), .c_bpc(B2), .c_clk_div(D2), .c_lat_cycles(L)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .o_addr(addr2), .i_data(data2),
    .o_sclk(sclk2), .o_sdi(sdi2), .o_lat(lat2), .o_blank(blank2), .o_drq(drq2), .o_busy(busy2)
  );

  // Registered-read frame buffers
  logic [11:0] mem [0:C-1];
  always @(posedge clk) data  <= mem[addr];
  always @(posedge clk) data2 <= {3'b100, addr2};

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  // Observations of the main instance, taken on the falling edge
  bit cap_q[$];
  int addr_q[$], drq_q[$], lat_len_q[$], lat_end_q[$], blank_fall_q[$];
  int stab_bad = 0, overlap_bad = 0;

  initial begin
    logic p_sclk, p_sdi, p_lat, p_blank;
    int   lat_run;
    p_sclk = 1'b0; p_sdi = 1'b0; p_lat = 1'b0; p_blank = 1'b1; lat_run = 0;
    forever begin
      @(negedge clk);
      if (!p_sclk && sclk) begin
        cap_q.push_back(sdi);
        addr_q.push_back(int'(addr));
        if (sdi !== p_sdi) stab_bad++;
      end
      if (drq) drq_q.push_back(cyc);
      if (lat) begin
        lat_run++;
        if (sclk) overlap_bad++;
      end else if (p_lat) begin
        lat_len_q.push_back(lat_run);
        lat_end_q.push_back(cyc - 1);
        lat_run = 0;
      end
      if (p_blank && !blank) blank_fall_q.push_back(cyc);
      p_sclk = sclk; p_sdi = sdi; p_lat = lat; p_blank = blank;
    end
  end

  // Observations of the second instance: phase lengths and data stability
  bit cap2_q[$];
  int drq2_q[$];
  int hi_bad2 = 0, lo_bad2 = 0, stab_bad2 = 0;

  initial begin
    logic p_sclk2, p_sdi2;
    int   hi_run2, lo_run2, rise2;
    p_sclk2 = 1'b0; p_sdi2 = 1'b0; hi_run2 = 0; lo_run2 = 0; rise2 = 0;
    forever begin
      @(negedge clk);
      if (rst2 === 1'b0) begin
        if (!p_sclk2 && sclk2) begin
          if ((rise2 % B2) != 0 && lo_run2 != D2) lo_bad2++;
          if (sdi2 !== p_sdi2) stab_bad2++;
          if (cap2_q.size() < B2) cap2_q.push_back(sdi2);
          rise2++;
          lo_run2 = 0;
        end
        if (p_sclk2 && !sclk2) begin
          if (hi_run2 != D2) hi_bad2++;
          hi_run2 = 0;
        end
        if (sclk2) hi_run2++;
        else lo_run2++;
        if (drq2) drq2_q.push_back(cyc);
        p_sclk2 = sclk2; p_sdi2 = sdi2;
      end
    end
  end

  // Reference: a frame is every channel, top address first, each value MSB first
  bit exp_q[$];
  function automatic void model_frame();
    for (int a = C - 1; a >= 0; a--)
      for (int b = B - 1; b >= 0; b--)
        exp_q.push_back(mem[a][b]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drq(input int n, input string tag);
    int k;
    k = 0;
    while (drq_q.size() <= n && k < 3000) begin
      tick(1);
      k++;
    end
    chk(tag, drq_q.size(), n + 1);
  endtask

  task automatic clear_mon();
    cap_q.delete(); addr_q.delete(); drq_q.delete();
    lat_len_q.delete(); lat_end_q.delete(); blank_fall_q.delete();
    exp_q.delete();
    stab_bad = 0; overlap_bad = 0;
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) bad++;
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    chk({tag, "_bits"}, bad, 0);
  endtask

  initial begin
    int          en_cyc, rel_cyc, n0, bad;
    logic [11:0] w;
    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
    for (int k = 0; k < C; k++) mem[k] = 12'h800 | 12'(k);
    tick(3);
    rst = 1'b0; rst2 = 1'b0; en2 = 1'b1;
    rel_cyc = cyc;
    clear_mon();

    // Idle with enable low
    for (int i = 0; i < 50; i++) begin
      chk("idle_outputs", {blank, busy, sclk, sdi, lat, drq, addr}, {6'b100000, 5'd0});
      tick(1);
    end
    chk("idle_no_sclk", cap_q.size(), 0);

    // Single frame from a one-cycle enable pulse
    model_frame();
    en = 1'b1; en_cyc = cyc;
    tick(1);
    en = 1'b0;
    chk("fetch_top_addr", {busy, addr}, {1'b1, 5'd31});
    wait_drq(0, "single_drq_seen");
    if (drq_q.size() > 0) chk("single_frame_len", drq_q[0] - en_cyc + 1, FRAME);
    tick(1);
    chk("drq_one_cycle", {drq, busy}, 2'b00);
    chk("single_rises", cap_q.size(), C * B);
    w = '0;
    for (int i = 0; i < B && i < cap_q.size(); i++) w = {w[10:0], cap_q[i]};
    chk("first_word", w, 12'h81F);
    w = '0;
    for (int i = 0; i < B && cap_q.size() >= B; i++) w = {w[10:0], cap_q[cap_q.size() - B + i]};
    chk("last_word", w, 12'h800);
    cmp_stream("single_stream");
    bad = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != C - 1 - i / B) bad++;
    chk("addr_sequence", bad, 0);
    chk("lat_pulses", lat_len_q.size(), 1);
    if (lat_len_q.size() > 0) chk("lat_width", lat_len_q[0], L);
    if (lat_end_q.size() > 0 && drq_q.size() > 0) chk("drq_after_lat", drq_q[0], lat_end_q[0] + 1);
    if (blank_fall_q.size() > 0 && drq_q.size() > 0) chk("blank_fall", blank_fall_q[0], drq_q[0]);
    chk("blank_fell_once", blank_fall_q.size(), 1);
    chk("sclk_during_lat", overlap_bad, 0);
    chk("sdi_stable", stab_bad, 0);

    // Back-to-back frames over random buffer contents
    tick(5);
    clear_mon();
    for (int k = 0; k < C; k++) mem[k] = 12'($urandom);
    repeat (3) model_frame();
    en = 1'b1;
    wait_drq(0, "b2b_drq0");
    wait_drq(1, "b2b_drq1");
    wait_drq(2, "b2b_drq2");
    if (drq_q.size() >= 3) begin
      chk("b2b_period_a", drq_q[1] - drq_q[0], FRAME);
      chk("b2b_period_b", drq_q[2] - drq_q[1], FRAME);
    end
    chk("b2b_blank_low", blank, 1'b0);
    chk("b2b_no_blank_edge", blank_fall_q.size(), 0);
    cmp_stream("b2b_stream");

    // Enable dropped part-way through the fourth frame
    n0 = cap_q.size();
    model_frame();
    tick($urandom_range(20, 700));
    en = 1'b0;
    wait_drq(3, "drop_drq");
    chk("drop_rises", cap_q.size() - n0, C * B);
    cmp_stream("drop_stream");
    tick(1);
    chk("drop_busy_low", {busy, drq}, 2'b00);
    n0 = cap_q.size();
    tick(100);
    chk("drop_no_more_sclk", cap_q.size(), n0);
    chk("drop_no_more_drq", drq_q.size(), 4);
    chk("drop_still_idle", busy, 1'b0);

    // Reset during channel 10, bit 5
    clear_mon();
    en = 1'b1;
    for (int k = 0; k < 3000 && cap_q.size() < 258; k++) tick(1);
    chk("mid_addr", addr, 5'd10);
    rst = 1'b1;
    tick(1);
    chk("rst_outputs", {blank, busy, sclk, sdi, lat, drq, addr}, {6'b100000, 5'd0});
    rst = 1'b0;
    en_cyc = cyc;
    clear_mon();
    model_frame();
    tick(1);
    en = 1'b0;
    chk("rst_restart_addr", {busy, addr}, {1'b1, 5'd31});
    wait_drq(0, "rst_drq");
    if (drq_q.size() > 0) chk("rst_frame_len", drq_q[0] - en_cyc + 1, FRAME);
    cmp_stream("rst_stream");

    // Second instance: divider 3, 8 bits per channel
    chk("div_drq_count", drq2_q.size() >= 2, 1'b1);
    if (drq2_q.size() >= 2) begin
      chk("div_first_frame", drq2_q[0] - rel_cyc + 1, FRAME2);
      chk("div_period", drq2_q[1] - drq2_q[0], FRAME2);
    end
    chk("div_high_phase", hi_bad2, 0);
    chk("div_low_phase", lo_bad2, 0);
    chk("div_sdi_stable", stab_bad2, 0);
    w = '0;
    for (int i = 0; i < cap2_q.size(); i++) w = {w[10:0], cap2_q[i]};
    chk("div_first_word", w, 12'h09F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_shifter.md
Name: led_shifter

Overview:
- Frame-buffer readout stage directly downstream of the animator.
- Reads every channel from the read port of the dual-port frame buffer, highest address first, and serialises each c_bpc-bit value MSB-first onto the daisy-chained LED driver boards.
- After the last bit it pulses the latch, then issues a one-cycle data request (o_drq) that drives the animator's i_drq to start computing the next frame.

Parameters:
- c_ledboards, 30, number of daisy-chained LED driver boards.
- c_bpc, 12, bits per channel.
- c_channels, c_ledboards*32, total channels per frame.
- c_addr_w, $clog2(c_channels), frame buffer address width.
- c_clk_div, 2, i_clk cycles per o_sclk half-period (>=1).
- c_lat_cycles, 2, o_lat high duration in i_clk cycles (>=1).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  frame enable; frames run back-to-back while high.
- o_addr  out  c_addr_w  frame buffer read address, registered.
- i_data  in  c_bpc  frame buffer read data; valid one cycle after o_addr changes (registered RAM).
- o_sclk  out  1  serial clock to drivers; idles low.
- o_sdi  out  1  serial data to drivers; MSB first.
- o_lat  out  1  latch pulse to drivers.
- o_blank  out  1  driver blank; high from reset until the first latch completes.
- o_drq  out  1  one-cycle frame-done request to the animator.
- o_busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset: the cycle after i_rst is sampled high, all outputs take their reset values and the state is S_IDLE, including mid-frame. Reset values: o_addr=0, o_sclk=0, o_sdi=0, o_lat=0, o_blank=1, o_drq=0, o_busy=0. Shift register and counters are cleared.
- All outputs are registered. No combinational path from any input to any output.
- S_IDLE: if i_en=1, set o_addr<=c_channels-1 and go to S_FETCH. Otherwise stay.
- S_FETCH: one cycle of RAM latency, then go to S_LOAD.
- S_LOAD: capture i_data into the c_bpc-bit shift register, clear the bit and phase counters, go to S_SHIFT.
- S_SHIFT, per bit:
  - o_sdi = shift register MSB, stable for the whole bit.
  - o_sclk low for c_clk_div cycles, then high for c_clk_div cycles.
  - At the end of the high phase, o_sclk<=0, the register shifts left and the bit count increments.
  - Drivers sample o_sdi on the o_sclk rising edge.
  - After c_bpc bits: if o_addr==0 go to S_LATCH; otherwise o_addr<=o_addr-1 and go to S_FETCH.
- S_LATCH: o_lat high for exactly c_lat_cycles cycles, o_sclk low throughout. On the final cycle clear o_blank (it stays 0 until reset). Then go to S_DRQ.
- S_DRQ: o_drq=1 for exactly one cycle, then go to S_IDLE. The next frame starts the following cycle if i_en is still 1.
- Frame period: 1 + c_channels*(2 + 2*c_clk_div*c_bpc) + c_lat_cycles + 1 cycles.
- i_en deasserted mid-frame: the current frame completes, including latch and drq. The block then stays in S_IDLE.
- i_en is sampled only in S_IDLE.
- Address wrap: o_addr never decrements below 0. The frame ends at address 0.
- Arithmetic: counters are sized from the parameters. o_addr reloads to c_channels-1 truncated to c_addr_w; no other modular wrap is used.

Test Plan:
- Bench parameters: c_ledboards=1 (32 channels), c_bpc=12, c_clk_div=1, c_lat_cycles=2. Frame buffer model: addr k holds 12'h800|k.
- Reset/idle: hold i_rst 3 cycles, then i_en=0 for 50 cycles -> o_blank=1, o_busy=0, o_sclk=0, o_lat=0, o_drq=0, o_addr=0 throughout.
- Single frame: pulse i_en for 1 cycle -> o_addr sequence 31..0. First 12 bits captured on o_sclk rising edges = 12'h81F, last 12 = 12'h800. Exactly 384 rising edges. o_lat high 2 cycles, then o_drq one cycle. Frame = 836 cycles from i_en sample to o_drq. o_blank falls at latch end.
- Back-to-back: i_en held high -> o_drq pulses exactly 836 cycles apart. o_blank stays 0 after the first frame.
- Reset mid-frame: assert i_rst during channel 10 bit 5 -> next cycle all outputs at reset values (o_blank=1). With i_en=1, a full fresh frame starts from o_addr=31.
- Enable drop: deassert i_en mid-frame -> the frame completes with one o_drq. o_busy falls the cycle after o_drq. No further o_sclk edges.
- Divider/width: c_clk_div=3, c_bpc=8 -> o_sclk high and low phases each 3 cycles. o_sdi stable across each rising edge. Frame = 1+32*(2+48)+2+1 = 1604 cycles.
